// File: rtl/async_input_filter_pkg.sv
// -----------------------------------------------------------------------------
// async_input_pkg
// Shared constants and helpers for the asynchronous input filter:
//   - legality minimums for the top-level parameters
//   - counter width helper max(1, clog2(n))
// -----------------------------------------------------------------------------
package async_input_pkg;

    // Smallest legal parameter values; the top fatals below these.
    localparam int unsigned MIN_CHANNELS      = 1;
    localparam int unsigned MIN_SYNC_STAGES   = 2;
    localparam int unsigned MIN_FILTER_CYCLES = 1;

    // Width of the per-channel stability counter: max(1, clog2(n)).
    // The counter only ever reaches n-1, so clog2(n) bits always suffice.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : async_input_pkg

// File: rtl/async_input_filter_chan.sv
// -----------------------------------------------------------------------------
// async_input_filter_chan
// One channel of the asynchronous input conditioner: an N-stage synchronizer
// followed by a glitch filter that accepts a new level only after it has held
// for FILTER_CYCLES consecutive cycles, plus optional rise/fall pulse flops.
//
// Build option: ASYNC_INPUT_FILTER_EDGE_EN
//   defined   -> rise/fall are registered one-cycle pulses on each accepted edge
//   undefined -> no edge flops, rise/fall are tied to 0
//
// Ports:
//   clk        in   sole clock
//   rst_n      in   asynchronous active-low reset
//   async_in   in   raw asynchronous input
//   sync_out   out  last synchronizer stage (raw synchronized level)
//   stable_out out  filtered, qualified level
//   rise       out  one-cycle pulse on accepted 0->1
//   fall       out  one-cycle pulse on accepted 1->0
// -----------------------------------------------------------------------------
module async_input_filter_chan
    import async_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic stable_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W   = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    // Synchronizer chain; every stage is a metastability-hardened flop.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sync_lvl_c;
    logic             accept_c;

    // Shift the raw input into the chain, oldest sample at the top bit.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    assign sync_lvl_c = sync_q[SYNC_STAGES-1];

    // A differing level is accepted on the cycle its hold count reaches the end.
    assign accept_c = (sync_lvl_c != stable_q) && (cnt_q == CNT_MAX);

    // Glitch filter: any return to the stable level restarts the count,
    // and the count never runs past CNT_MAX.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_lvl_c == stable_q) begin
            cnt_d = '0;
        end else if (accept_c) begin
            stable_d = sync_lvl_c;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchronizer and filter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
            stable_q <= RESET_LEVEL;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync_out   = sync_lvl_c;
    assign stable_out = stable_q;

`ifdef ASYNC_INPUT_FILTER_EDGE_EN
    logic rise_q;
    logic rise_d;
    logic fall_q;
    logic fall_d;

    // Pulses are loaded on the same edge that updates stable_q, so they line
    // up with the first cycle of the new filtered level.
    always_comb begin
        rise_d = accept_c &  sync_lvl_c;
        fall_d = accept_c & ~sync_lvl_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    // Edge detection not built; ports kept for a stable interface.
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule : async_input_filter_chan

// File: rtl/async_input_filter.sv
// -----------------------------------------------------------------------------
// async_input_filter
// Multi-channel conditioner for asynchronous inputs. Each channel is an
// independent synchronizer + glitch filter (async_input_filter_chan); there is
// no cross-channel coherency.
//
// Build option: ASYNC_INPUT_FILTER_EDGE_EN enables the RISE/FALL pulse flops;
// without it RISE and FALL are constant 0.
//
// Parameters:
//   CHANNELS      number of channels (>= 1)
//   SYNC_STAGES   synchronizer depth (>= 2)
//   FILTER_CYCLES cycles a new level must hold before acceptance (>= 1)
//   RESET_LEVEL   reset value of every synchronizer and filter flop
//
// Ports:
//   CLK        in   sole clock
//   RST_N      in   asynchronous active-low reset
//   ASYNC_IN   in   [CHANNELS] asynchronous inputs
//   SYNC_OUT   out  [CHANNELS] raw synchronized levels
//   STABLE_OUT out  [CHANNELS] filtered levels
//   RISE       out  [CHANNELS] one-cycle pulse on filtered 0->1
//   FALL       out  [CHANNELS] one-cycle pulse on filtered 1->0
// -----------------------------------------------------------------------------
module async_input_filter
    import async_input_pkg::*;
#(
    parameter int unsigned CHANNELS      = 1,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] ASYNC_IN,
    output logic [CHANNELS-1:0] SYNC_OUT,
    output logic [CHANNELS-1:0] STABLE_OUT,
    output logic [CHANNELS-1:0] RISE,
    output logic [CHANNELS-1:0] FALL
);

    // Reject illegal configurations at elaboration.
    if (CHANNELS < MIN_CHANNELS) begin : g_bad_channels
        $fatal(1, "async_input_filter: CHANNELS=%0d, must be >= %0d",
               CHANNELS, MIN_CHANNELS);
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $fatal(1, "async_input_filter: SYNC_STAGES=%0d, must be >= %0d",
               SYNC_STAGES, MIN_SYNC_STAGES);
    end
    if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter
        $fatal(1, "async_input_filter: FILTER_CYCLES=%0d, must be >= %0d",
               FILTER_CYCLES, MIN_FILTER_CYCLES);
    end

    // One independent conditioner per channel.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        async_input_filter_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RST_N),
            .async_in  (ASYNC_IN[ch]),
            .sync_out  (SYNC_OUT[ch]),
            .stable_out(STABLE_OUT[ch]),
            .rise      (RISE[ch]),
            .fall      (FALL[ch])
        );
    end

endmodule : async_input_filter

// File: tb/tb_async_input_filter.sv
// -----------------------------------------------------------------------------
// tb_async_input_filter
// Directed scoreboard bench. Stimulus pushes per-cycle expected outputs into a
// queue keyed by cycle number; a negedge monitor pops and compares them.
// DUT A: 4 channels, defaults (2 stages, 4 filter cycles).
// DUT B: 4 channels, FILTER_CYCLES=1.
// -----------------------------------------------------------------------------
module tb_async_input_filter;

`ifdef ASYNC_INPUT_FILTER_EDGE_EN
    localparam logic [3:0] EDGE_MASK = 4'hF;
`else
    localparam logic [3:0] EDGE_MASK = 4'h0;
`endif

    typedef struct {
        int         dut;
        int         cyc;
        logic [3:0] s;
        logic [3:0] st;
        logic [3:0] r;
        logic [3:0] f;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_in, a_sync, a_stable, a_rise, a_fall;
    logic [3:0] b_in, b_sync, b_stable, b_rise, b_fall;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    async_input_filter #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_LEVEL(1'b0)
    ) u_dut_a (
        .CLK(clk), .RST_N(rst_n), .ASYNC_IN(a_in), .SYNC_OUT(a_sync),
        .STABLE_OUT(a_stable), .RISE(a_rise), .FALL(a_fall)
    );

    async_input_filter #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .RESET_LEVEL(1'b0)
    ) u_dut_b (
        .CLK(clk), .RST_N(rst_n), .ASYNC_IN(b_in), .SYNC_OUT(b_sync),
        .STABLE_OUT(b_stable), .RISE(b_rise), .FALL(b_fall)
    );

    // Expected edge pulses only exist when the edge flops are built.
    function automatic logic [3:0] er(input logic [3:0] v);
        return v & EDGE_MASK;
    endfunction

    task automatic expect_at(input int dut, input int c, input logic [3:0] s,
                             input logic [3:0] st, input logic [3:0] r,
                             input logic [3:0] f, input string nm);
        exp_t e;
        e.dut = dut; e.cyc = c; e.s = s; e.st = st; e.r = r; e.f = f; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Monitor: compare every entry due this cycle, flag any that were missed.
    always @(negedge clk) begin
        logic [3:0] s, st, r, f;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                if (sb[i].dut == 0) begin
                    s = a_sync; st = a_stable; r = a_rise; f = a_fall;
                end else begin
                    s = b_sync; st = b_stable; r = b_rise; f = b_fall;
                end
                n_checks++;
                if (sb[i].cyc < cyc) begin
                    n_fails++;
                    $display("FAIL %s: dut%0d expectation for cycle %0d missed (now %0d)",
                             sb[i].name, sb[i].dut, sb[i].cyc, cyc);
                end else if (s !== sb[i].s || st !== sb[i].st ||
                             r !== sb[i].r || f !== sb[i].f) begin
                    n_fails++;
                    $display("FAIL %s: dut%0d cyc %0d got sync=%b stable=%b rise=%b fall=%b, expected sync=%b stable=%b rise=%b fall=%b",
                             sb[i].name, sb[i].dut, cyc, s, st, r, f,
                             sb[i].s, sb[i].st, sb[i].r, sb[i].f);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int c;
        int r0;
        logic [10:0] b_sync_tab, b_stab_tab, b_rise_tab, b_fall_tab;

        rst_n = 1'b0;
        a_in  = 4'b0001;
        b_in  = 4'b0000;

        // Reset: input held high on ch0 while in reset, outputs stay at 0.
        wait_until(3);
        expect_at(0, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "reset_hold_a");
        expect_at(1, 3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "reset_hold_b");
        tick();
        r0 = cyc;
        rst_n = 1'b1;
        expect_at(0, r0 + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "release_no_pulse");
        expect_at(0, r0 + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "sync_after_2");
        expect_at(0, r0 + 5, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "not_yet_stable");
        expect_at(0, r0 + 6, 4'b0001, 4'b0001, er(4'b0001), 4'b0000, "stable_at_6");
        expect_at(0, r0 + 7, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "rise_one_cycle");
        wait_until(r0 + 10);

        // Short glitch on ch2: 3 cycles at SYNC_OUT, must be rejected.
        c = cyc;
        a_in = 4'b0101;
        expect_at(0, c + 2, 4'b0101, 4'b0001, 4'b0000, 4'b0000, "glitch_sync");
        expect_at(0, c + 4, 4'b0101, 4'b0001, 4'b0000, 4'b0000, "glitch_hold");
        expect_at(0, c + 5, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "glitch_gone");
        expect_at(0, c + 6, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "glitch_reject_6");
        expect_at(0, c + 7, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "glitch_reject_7");
        wait_until(c + 3);
        a_in = 4'b0001;
        wait_until(c + 10);

        // Threshold pulse on ch2: exactly 4 cycles at SYNC_OUT, accepted.
        c = cyc;
        a_in = 4'b0101;
        expect_at(0, c + 5, 4'b0101, 4'b0001, 4'b0000, 4'b0000, "thr_pending");
        expect_at(0, c + 6, 4'b0001, 4'b0101, er(4'b0100), 4'b0000, "thr_rise");
        expect_at(0, c + 7, 4'b0001, 4'b0101, 4'b0000, 4'b0000, "thr_rise_end");
        expect_at(0, c + 9, 4'b0001, 4'b0101, 4'b0000, 4'b0000, "thr_fall_pending");
        expect_at(0, c + 10, 4'b0001, 4'b0001, 4'b0000, er(4'b0100), "thr_fall");
        expect_at(0, c + 11, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "thr_fall_end");
        wait_until(c + 4);
        a_in = 4'b0001;
        wait_until(c + 13);

        // Reset mid-count on ch3 after 2 qualifying cycles.
        c = cyc;
        a_in = 4'b1001;
        expect_at(0, c + 2, 4'b1001, 4'b0001, 4'b0000, 4'b0000, "midcnt_sync");
        expect_at(0, c + 3, 4'b1001, 4'b0001, 4'b0000, 4'b0000, "midcnt_count");
        wait_until(c + 4);
        rst_n = 1'b0;
        expect_at(0, c + 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "midcnt_reset_now");
        expect_at(0, c + 5, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "midcnt_reset_hold");
        wait_until(c + 6);
        r0 = cyc;
        rst_n = 1'b1;
        expect_at(0, r0 + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "requal_no_pulse");
        expect_at(0, r0 + 2, 4'b1001, 4'b0000, 4'b0000, 4'b0000, "requal_sync");
        expect_at(0, r0 + 5, 4'b1001, 4'b0000, 4'b0000, 4'b0000, "requal_full_count");
        expect_at(0, r0 + 6, 4'b1001, 4'b1001, er(4'b1001), 4'b0000, "requal_rise");
        wait_until(r0 + 9);

        // FILTER_CYCLES=1, ch2 toggling every 2 cycles: every edge pulses.
        b_sync_tab = 11'h0CC;
        b_stab_tab = 11'h198;
        b_rise_tab = 11'h088;
        b_fall_tab = 11'h220;
        c = cyc;
        for (int k = 2; k <= 10; k++) begin
            expect_at(1, c + k,
                      {1'b0, b_sync_tab[k], 2'b00},
                      {1'b0, b_stab_tab[k], 2'b00},
                      er({1'b0, b_rise_tab[k], 2'b00}),
                      er({1'b0, b_fall_tab[k], 2'b00}),
                      $sformatf("fc1_toggle_k%0d", k));
        end
        b_in = 4'b0100;
        wait_until(c + 2);
        b_in = 4'b0000;
        wait_until(c + 4);
        b_in = 4'b0100;
        wait_until(c + 6);
        b_in = 4'b0000;
        wait_until(c + 12);

        // Both high channels of DUT A fall together.
        c = cyc;
        a_in = 4'b0000;
        expect_at(0, c + 5, 4'b0000, 4'b1001, 4'b0000, 4'b0000, "fall_pending");
        expect_at(0, c + 6, 4'b0000, 4'b0000, 4'b0000, er(4'b1001), "fall_both");
        expect_at(0, c + 7, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "fall_end");
        wait_until(c + 9);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_async_input_filter

// File: doc/async_input_filter.md
# async_input_filter

Multi-channel conditioner for asynchronous inputs such as pins, strobes and status lines from foreign clock domains. It is the parametrised successor to the plain shift-register synchronizer. Each channel passes through an N-stage synchronizer and then a digital glitch filter, which qualifies a level only once it has been stable for a programmable number of cycles. The block emits the raw synchronized level, the filtered level and single-cycle rise/fall event pulses, and sits at the boundary between external signals and NetBus control logic.

## Interface
- CHANNELS, 1: number of independent input channels, ≥1.
- SYNC_STAGES, 2: synchronizer flop stages per channel, ≥2.
- FILTER_CYCLES, 4: consecutive cycles a new synchronized level must hold before it is accepted, ≥1.
- RESET_LEVEL, 1'b0: level loaded into every synchronizer and filter flop on reset, applied to all channels.

Ports:
- CLK  in  1  Sole clock.
- RST_N  in  1  Reset, asynchronous, active-low.
- ASYNC_IN  in  CHANNELS  Asynchronous inputs.
- SYNC_OUT  out  CHANNELS  Last synchronizer stage (raw synchronized level).
- STABLE_OUT  out  CHANNELS  Filtered, qualified level.
- RISE  out  CHANNELS  One-cycle pulse when STABLE_OUT goes 0→1.
- FALL  out  CHANNELS  One-cycle pulse when STABLE_OUT goes 1→0.

## Operation
- Channels are fully independent; there is no cross-channel coherency guarantee.
- Synchronizer per channel: shift register of SYNC_STAGES flops, all carrying the ASYNC_REG="TRUE" attribute. SYNC_OUT is the last stage.
- Filter per channel: state is `stable` (drives STABLE_OUT) plus counter `cnt`. Counter width is max(1, clog2(FILTER_CYCLES)).
  - SYNC_OUT == stable: cnt ← 0.
  - SYNC_OUT != stable and cnt == FILTER_CYCLES−1: stable ← SYNC_OUT, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
- Any return of SYNC_OUT to `stable` before acceptance restarts the count. Shorter glitches therefore never reach STABLE_OUT.
- The counter never wraps. Its maximum value is FILTER_CYCLES−1.
- RISE/FALL are registered in the same clock edge that updates `stable`, so each pulse coincides with the first cycle of the new STABLE_OUT level. Each pulse lasts exactly one cycle.
- Back-to-back accepted transitions are possible only with FILTER_CYCLES=1. In that case pulses may occur on consecutive cycles.
- Reset values (RST_N low, asynchronous):
  - all synchronizer stages, SYNC_OUT and STABLE_OUT = RESET_LEVEL;
  - cnt = 0;
  - RISE = FALL = 0.
- Reset asserted mid-count discards the partial count.
- Reset deassertion itself never produces a RISE/FALL pulse.

## Timing
- ASYNC_IN change (meeting setup) → SYNC_OUT after SYNC_STAGES rising edges.
- ASYNC_IN change → STABLE_OUT/RISE/FALL after SYNC_STAGES+FILTER_CYCLES edges. Defaults: 2 and 6.
- Minimum accepted pulse width at SYNC_OUT is FILTER_CYCLES cycles. FILTER_CYCLES−1 cycles is always rejected.
- All outputs are registered. There is no combinational path from ASYNC_IN.

## Configuration
- ASYNC_INPUT_FILTER_EDGE_EN defined: edge-pulse registers are built and RISE/FALL behave as above.
- Not defined: edge registers are omitted. RISE and FALL ports remain and are tied constant 0. SYNC_OUT and STABLE_OUT are unchanged.

## Structure
- Package async_input_pkg holds:
  - the counter-width function max(1, clog2(n));
  - parameter-legality constants (minimum SYNC_STAGES=2, minimum FILTER_CYCLES=1).
- Top elaborates a generate loop over CHANNELS, instantiating one sub-module per channel: async_input_filter_chan, a single-bit synchronizer plus filter plus edge logic.
- Top checks parameters at elaboration and fatals on illegal values.

## Test plan
- **Reset:** RESET_LEVEL=0, ASYNC_IN=1 held during reset. Expect all outputs 0 during reset. After release, SYNC_OUT=1 at edge 2, STABLE_OUT=1 and a single RISE pulse at edge 6, and no pulse at release.
- **Short glitch:** defaults, 0→1 glitch lasting 3 cycles at SYNC_OUT. Expect STABLE_OUT to stay 0 and no RISE/FALL.
- **Threshold pulse:** 4-cycle high pulse. Expect STABLE_OUT high 4 cycles later, RISE once, then FALL once after the return to low is qualified.
- **Independence:** CHANNELS=4, toggle channel 2 only. Expect only bit 2 of STABLE_OUT/RISE/FALL to change. With FILTER_CYCLES=1, alternate levels each 2 cycles and expect a pulse for every transition.
- **Reset mid-count:** assert RST_N after 2 qualifying cycles. Expect immediate return to RESET_LEVEL and cnt=0; after release, requalification takes the full 6 edges.
- **Macro undefined:** rerun the reset and threshold-pulse cases. Expect RISE=FALL=0 throughout and STABLE_OUT unchanged.
